// File: rtl/sine_analyzer.sv
// Rising zero-crossing analyzer for a strobed signed sine stream: reports the period in
// samples and the signed peaks of each cycle, with hysteresis and a sample-count timeout.
module sine_analyzer #(
    parameter int              W          = 16,
    parameter int              HYST       = 256,
    parameter int              CNT_W      = 32,
    parameter longint unsigned MAX_PERIOD = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic signed [W-1:0] sample,
    output logic [CNT_W-1:0]    period,
    output logic signed [W-1:0] peak_pos,
    output logic signed [W-1:0] peak_neg,
    output logic                meas_valid,
    output logic                locked,
    output logic                lost
);
    // state  | meaning
    // S_WAIT | no low excursion seen since reset or timeout
    // S_LOW  | at or below -HYST, armed for a rising crossing
    // S_HIGH | crossed +HYST, waiting for the next low excursion
    typedef enum logic [1:0] {S_WAIT, S_LOW, S_HIGH} state_t;

    localparam logic signed [W-1:0] HYST_P    = W'(HYST);
    localparam logic signed [W-1:0] HYST_N    = -HYST_P;
    localparam logic signed [W-1:0] SMAX      = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN      = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0]    CNT_LIMIT = CNT_W'(MAX_PERIOD);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                first_seen;
    logic signed [W-1:0] run_max;
    logic signed [W-1:0] run_min;
    logic signed [W-1:0] upd_max;
    logic signed [W-1:0] upd_min;
    logic [CNT_W-1:0]    cnt_inc;
    logic                rise;

    // The current sample folds into the running extremes before anything is latched.
    always_comb begin
        upd_max = (sample > run_max) ? sample : run_max;
        upd_min = (sample < run_min) ? sample : run_min;
        cnt_inc = cnt + CNT_W'(1);
        rise    = (state == S_LOW) && (sample >= HYST_P);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_WAIT;
            cnt        <= '0;
            first_seen <= 1'b0;
            run_max    <= SMIN;
            run_min    <= SMAX;
            period     <= '0;
            peak_pos   <= '0;
            peak_neg   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            lost       <= 1'b0;
            if (sample_valid) begin
                if (sample <= HYST_N) begin
                    state <= S_LOW;
                end else if (rise) begin
                    state <= S_HIGH;
                end

                if (rise) begin
                    run_max    <= SMIN;
                    run_min    <= SMAX;
                    cnt        <= '0;
                    first_seen <= 1'b1;
                    if (first_seen) begin
                        period     <= cnt_inc;
                        peak_pos   <= upd_max;
                        peak_neg   <= upd_min;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                    end
                end else begin
                    run_max <= upd_max;
                    run_min <= upd_min;
                    if (first_seen) begin
                        // Timeout takes priority over the state move made above.
                        if (cnt_inc == CNT_LIMIT) begin
                            lost       <= 1'b1;
                            locked     <= 1'b0;
                            first_seen <= 1'b0;
                            cnt        <= '0;
                            state      <= S_WAIT;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sine_analyzer.sv
// Directed bench for sine_analyzer: sample-level reference model checked every cycle,
// plus literal expectations for periods, peaks, boundaries, timeout and async reset.
module tb_sine_analyzer;
    localparam int HYST = 256;
    localparam int MAXP = 100;

    logic               clk;
    logic               reset;
    logic               sample_valid;
    logic signed [15:0] sample;
    logic [31:0]        period;
    logic signed [15:0] peak_pos;
    logic signed [15:0] peak_neg;
    logic               meas_valid;
    logic               locked;
    logic               lost;

    sine_analyzer #(.W(16), .HYST(HYST), .CNT_W(32), .MAX_PERIOD(MAXP)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .period(period), .peak_pos(peak_pos), .peak_neg(peak_neg),
        .meas_valid(meas_valid), .locked(locked), .lost(lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int meas_cnt = 0;

    // Reference model: works on sample indices and a list of the samples in the current cycle.
    bit  armed, seen;
    int  idx, last_ev;
    int  cyc[$];
    longint exp_period, exp_pos, exp_neg;
    bit  exp_mv, exp_locked, exp_lost;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        armed = 0; seen = 0; idx = 0; last_ev = 0;
        cyc.delete();
        exp_period = 0; exp_pos = 0; exp_neg = 0;
        exp_mv = 0; exp_locked = 0; exp_lost = 0;
    endtask

    task automatic model_sample(input bit v, input int s);
        exp_mv = 0;
        exp_lost = 0;
        if (!v) return;
        idx++;
        if (armed && s >= HYST) begin
            armed = 0;
            if (seen) begin
                int mx = s;
                int mn = s;
                foreach (cyc[i]) begin
                    if (cyc[i] > mx) mx = cyc[i];
                    if (cyc[i] < mn) mn = cyc[i];
                end
                exp_period = idx - last_ev;
                exp_pos = mx;
                exp_neg = mn;
                exp_mv = 1;
                exp_locked = 1;
            end
            seen = 1;
            last_ev = idx;
            cyc.delete();
        end else begin
            if (s <= -HYST) armed = 1;
            cyc.push_back(s);
            if (seen && (idx - last_ev) == MAXP) begin
                exp_lost = 1;
                exp_locked = 0;
                seen = 0;
                armed = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("period", longint'(period), exp_period);
        check("peak_pos", longint'(peak_pos), exp_pos);
        check("peak_neg", longint'(peak_neg), exp_neg);
        check("meas_valid", longint'(meas_valid), longint'(exp_mv));
        check("locked", longint'(locked), longint'(exp_locked));
        check("lost", longint'(lost), longint'(exp_lost));
        if (meas_valid) meas_cnt++;
    endtask

    // Drive one clock's inputs, advance the model, then compare after the edge.
    task automatic step(input bit v, input int s);
        @(negedge clk);
        sample_valid = v;
        sample = 16'(s);
        model_sample(v, s);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic int sine40(input int k);
        return int'(10000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 40.0));
    endfunction

    int base;

    initial begin
        reset = 1'b0;
        sample_valid = 1'b0;
        sample = '0;
        model_reset();

        // Period and peaks, one sample per clock
        do_reset();
        base = meas_cnt;
        for (int k = 0; k <= 201; k++) begin
            step(1, sine40(k));
            if (k == 80) check("t1_no_meas_before_2nd", longint'(meas_cnt - base), 0);
            if (k == 81) begin
                check("t1_meas_valid", longint'(meas_valid), 1);
                check("t1_period", longint'(period), 40);
                check("t1_peak_pos", longint'(peak_pos), 10000);
                check("t1_peak_neg", longint'(peak_neg), -10000);
                check("t1_locked", longint'(locked), 1);
            end
        end
        check("t1_meas_count", longint'(meas_cnt - base), 4);

        // Strobe gaps: junk on the sample bus between strobes
        do_reset();
        base = meas_cnt;
        for (int k = 0; k <= 121; k++) begin
            step(1, sine40(k));
            for (int g = 0; g < 3; g++) step(0, int'($signed(16'($urandom))));
        end
        check("t2_period", longint'(period), 40);
        check("t2_meas_count", longint'(meas_cnt - base), 2);

        // Hysteresis: +-200 never arms
        do_reset();
        base = meas_cnt;
        for (int i = 0; i < 1000; i++) step(1, (i % 2 == 0) ? 200 : -200);
        check("t3_period", longint'(period), 0);
        check("t3_locked", longint'(locked), 0);
        check("t3_meas_count", longint'(meas_cnt - base), 0);
        for (int k = 0; k <= 121; k++) step(1, sine40(k));
        check("t3_locked_after_sine", longint'(locked), 1);
        check("t3_period_after_sine", longint'(period), 40);

        // Timeout: last event was the final sine sample
        for (int i = 1; i <= 100; i++) begin
            step(1, 0);
            if (i == 99) check("t4_lost_at_99", longint'(lost), 0);
            if (i == 100) begin
                check("t4_lost_at_100", longint'(lost), 1);
                check("t4_locked", longint'(locked), 0);
                check("t4_period_held", longint'(period), 40);
            end
        end
        for (int k = 0; k <= 121; k++) begin
            step(1, sine40(k));
            if (k == 80) check("t4_not_relocked_yet", longint'(locked), 0);
        end
        check("t4_relocked", longint'(locked), 1);

        // Boundary compares and full-scale peaks
        do_reset();
        step(1, -300);
        step(1, 300);
        step(1, -256);
        step(1, 255);
        step(1, 256);
        check("t5_period", longint'(period), 3);
        check("t5_peak_pos", longint'(peak_pos), 256);
        check("t5_peak_neg", longint'(peak_neg), -256);
        step(1, -32768);
        step(1, 32767);
        check("t5_period_fs", longint'(period), 2);
        check("t5_peak_pos_fs", longint'(peak_pos), 32767);
        check("t5_peak_neg_fs", longint'(peak_neg), -32768);

        // Async reset between edges while locked
        do_reset();
        for (int k = 0; k <= 95; k++) step(1, sine40(k));
        check("t6_locked_before", longint'(locked), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("t6_async_period", longint'(period), 0);
        check("t6_async_peak_pos", longint'(peak_pos), 0);
        check("t6_async_peak_neg", longint'(peak_neg), 0);
        check("t6_async_locked", longint'(locked), 0);
        check("t6_async_meas_valid", longint'(meas_valid), 0);
        @(negedge clk);
        sample_valid = 1'b0;
        reset = 1'b1;
        base = meas_cnt;
        for (int k = 0; k <= 80; k++) step(1, sine40(k));
        check("t6_no_meas_after_one", longint'(meas_cnt - base), 0);
        for (int k = 81; k <= 121; k++) step(1, sine40(k));
        check("t6_meas_after_two", longint'(meas_cnt - base), 2);
        check("t6_period", longint'(period), 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sine_analyzer.md
Name: sine_analyzer

Overview:
- Receive-side counterpart to the team's sine generator. Consumes a strobed stream of signed sine samples, e.g. a generator's sample value and its sample-edge strobe.
- Detects rising zero crossings with hysteresis, measures the period in samples, and reports the positive and negative peaks of each cycle.
- Used as an on-chip checker and frequency/amplitude monitor for the synthesis chain.

Parameters:
- W, 16: sample width; samples are two's-complement signed.
- HYST, 256: hysteresis threshold, positive and less than 2^(W-1).
- CNT_W, 32: width of the period counter and output.
- MAX_PERIOD, 1000000: sample-count timeout; must be at least 2 and at most 2^CNT_W-1.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous active-low reset (0 = reset).
- sample_valid, input, 1: one-cycle strobe marking a new sample.
- sample, input, W: signed sample, sampled only when sample_valid=1.
- period, output, CNT_W: samples between the last two rising crossings.
- peak_pos, output, W: signed maximum over the last measured cycle.
- peak_neg, output, W: signed minimum over the last measured cycle.
- meas_valid, output, 1: one-clk pulse when period/peak_pos/peak_neg update.
- locked, output, 1: high while consecutive measurements are valid.
- lost, output, 1: one-clk pulse on timeout.

Behaviour:
- Reset (reset=0, async), values held while low:
  - state=S_WAIT, cnt=0, first_seen=0.
  - run_max=-2^(W-1), run_min=2^(W-1)-1.
  - period=0, peak_pos=0, peak_neg=0.
  - meas_valid=0, locked=0, lost=0.
- Exit from reset is synchronous to clk. Reset mid-measurement discards all progress.
- Clock cycles with sample_valid=0 change nothing except clearing the meas_valid and lost pulses.
- FSM, evaluated only on valid samples (signed compares):
  - S_WAIT: sample <= -HYST -> S_LOW.
  - S_LOW: sample >= +HYST -> S_HIGH and flag a rising event on this sample.
  - S_HIGH: sample <= -HYST -> S_LOW.
  - Samples strictly between -HYST and +HYST never change state.
- Running stats on each valid sample: run_max = max(run_max, sample), run_min = min(run_min, sample). The current sample is included before any latch.
- Rising event with first_seen=0:
  - Set first_seen=1, cnt=0.
  - Reinitialise run_max and run_min to their reset values.
  - No meas_valid.
- Rising event with first_seen=1:
  - period <= cnt+1; peak_pos <= updated run_max; peak_neg <= updated run_min.
  - meas_valid=1 on the following clk edge, i.e. visible in the cycle after the event sample. Latency is 1 clk.
  - locked <= 1, cnt <= 0, run_max/run_min reinitialised.
- Valid non-event sample with first_seen=1: cnt <= cnt+1.
- Period semantics: events on valid-sample indices i and j give period = j-i.
- Timeout: on a valid non-event sample with first_seen=1 and cnt+1 == MAX_PERIOD:
  - lost pulses 1 clk; locked <= 0; first_seen <= 0; cnt <= 0; state <= S_WAIT.
  - period and peaks hold their last values.
- Without first_seen, cnt stays 0 and no timeout occurs.
- Outputs hold their values between updates. locked stays 1 across measurements until a timeout or reset.
- Arithmetic: cnt never wraps, because the timeout fires first. The peak registers are full W-bit signed.

Test Plan:
1. Period and peaks: reset low 2 clk, then a sine with amplitude 10000 and 40 samples per cycle, sample_valid every clk, starting at phase 0 -> first meas_valid after the second rising crossing, with period=40, peak_pos=10000, peak_neg=-10000, and locked=1. Every subsequent crossing gives period=40.
2. Strobe gaps: same waveform with sample_valid every 4th clk -> period=40 (counted in samples, not clocks). meas_valid is exactly 1 clk wide, the cycle after the event strobe.
3. Hysteresis: alternating samples +200/-200 for 1000 samples, HYST=256 -> no meas_valid, locked=0, period=0. Then a 10000-amplitude sine -> normal lock.
4. Timeout: MAX_PERIOD=100, lock on a 40-sample sine, then hold sample=0 -> lost pulses on the 100th valid sample after the last event, locked=0, and period stays 40. Resuming the sine relocks after two crossings.
5. Boundary compare: with HYST=256, feed -256, then 255 -> no event; then 256 -> event in S_LOW. Feeding -32768 and 32767 yields peak_neg=-32768 and peak_pos=32767 with no overflow.
6. Async reset mid-cycle: assert reset between clk edges while locked -> all outputs go to their reset values immediately. After release, the first measurement requires two new rising crossings.
